// File: rtl/free_list_ctrl_pkg.sv
// Shared rename-stage sizing constants and types for the physical-register free list.
package cpu_design_params;

    localparam int NUM_P_REGS    = 64;
    localparam int NUM_A_REGS    = 32;
    localparam int MAX_FREE_REGS = NUM_P_REGS - NUM_A_REGS;

    typedef logic [5:0] prn_t;
    // 5-bit list index plus a wrap bit, so full and empty are distinguishable
    typedef logic [5:0] fl_ptr_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fl_state_t;

endpackage

// File: rtl/free_list_ctrl.sv
// Circular free list of physical register numbers: speculative grant to rename,
// reclaim from commit, and head restore to the committed head on flush.
module free_list_ctrl #(
    parameter int NUM_P_REGS = cpu_design_params::NUM_P_REGS,
    parameter int NUM_A_REGS = cpu_design_params::NUM_A_REGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_req_i,
    output logic                     alloc_gnt_o,
    output cpu_design_params::prn_t  alloc_preg_o,
    input  logic                     commit_alloc_i,
    input  logic                     release_valid_i,
    input  cpu_design_params::prn_t  release_preg_i,
    input  logic                     flush_i,
    output logic [5:0]               free_cnt_o,
    output logic                     empty_o,
    output logic                     recover_busy_o,
    output logic                     err_o
);
    import cpu_design_params::*;

    localparam int DEPTH = NUM_P_REGS - NUM_A_REGS;
    localparam int IDX_W = $clog2(DEPTH);

    prn_t      free_list [DEPTH];
    fl_ptr_t   head;
    fl_ptr_t   commit_head;
    fl_ptr_t   tail;
    fl_state_t state;
    fl_ptr_t   free_cnt_q;
    logic      err_q;

    fl_ptr_t   com_cnt;
    fl_ptr_t   head_nxt;
    fl_ptr_t   commit_head_nxt;
    fl_ptr_t   tail_nxt;
    logic      rel_ok;
    logic      rel_drop;
    logic      com_ok;
    logic      com_bad;

    always_comb begin
        com_cnt     = tail - commit_head;
        alloc_gnt_o = alloc_req_i & (state == RUN) & ~flush_i & (free_cnt_q != '0);

        // A release can only be legal while some committed entry is outstanding
        rel_drop = release_valid_i & (com_cnt == fl_ptr_t'(DEPTH));
        rel_ok   = release_valid_i & ~rel_drop;
        com_bad  = commit_alloc_i & (commit_head == head);
        com_ok   = commit_alloc_i & ~com_bad;

        tail_nxt        = tail + fl_ptr_t'(rel_ok);
        commit_head_nxt = commit_head + fl_ptr_t'(com_ok);

        // Flush restores to the committed head including this cycle's commit
        if (flush_i) begin
            head_nxt = commit_head_nxt;
        end else begin
            head_nxt = head + fl_ptr_t'(alloc_gnt_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                free_list[i] <= prn_t'(NUM_A_REGS + i);
            end
            head        <= '0;
            commit_head <= '0;
            tail        <= fl_ptr_t'(DEPTH);
            free_cnt_q  <= fl_ptr_t'(DEPTH);
            err_q       <= 1'b0;
            state       <= RUN;
        end else begin
            if (rel_ok) begin
                free_list[tail[IDX_W-1:0]] <= release_preg_i;
            end
            head        <= head_nxt;
            commit_head <= commit_head_nxt;
            tail        <= tail_nxt;
            free_cnt_q  <= tail_nxt - head_nxt;
            err_q       <= err_q | rel_drop | com_bad;
            case (state)
                RUN:     state <= flush_i ? RECOVER : RUN;
                RECOVER: state <= flush_i ? RECOVER : RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign alloc_preg_o   = free_list[head[IDX_W-1:0]];
    assign free_cnt_o     = free_cnt_q;
    assign empty_o        = (free_cnt_q == '0);
    assign recover_busy_o = (state == RECOVER);
    assign err_o          = err_q;

endmodule
